// File: rtl/imm_encoder.sv
// imm_encoder: packs an immediate and register/opcode fields into an RV32I instruction word,
// flags immediates the selected format cannot represent, and counts delivered and errored beats.
module imm_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       imm_sel,
   input  logic [31:0]      imm,
   input  logic [6:0]       opcode,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [2:0]       funct3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      inst,
   output logic             err,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);
   localparam logic [2:0] I_TYPE = 3'd0, S_TYPE = 3'd1, B_TYPE = 3'd2, U_TYPE = 3'd3, J_TYPE = 3'd4;

   logic [31:0] packed_inst;
   logic        packed_err;
   logic        fits_11, fits_12, fits_20, hs;

   // An immediate fits when every bit above the format's sign bit copies it.
   assign fits_11 = &imm[31:11] | ~|imm[31:11];
   assign fits_12 = &imm[31:12] | ~|imm[31:12];
   assign fits_20 = &imm[31:20] | ~|imm[31:20];

   always_comb begin
      packed_inst = (imm_sel == I_TYPE) ? {imm[11:0], rs1, funct3, rd, opcode} :
                    (imm_sel == S_TYPE) ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
                    (imm_sel == B_TYPE) ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
                    (imm_sel == U_TYPE) ? {imm[31:12], rd, opcode} :
                    (imm_sel == J_TYPE) ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode} :
                                          {25'd0, opcode};
      packed_err  = (imm_sel == I_TYPE || imm_sel == S_TYPE) ? !fits_11 :
                    (imm_sel == B_TYPE) ? (!fits_12 || imm[0]) :
                    (imm_sel == U_TYPE) ? (|imm[11:0]) :
                    (imm_sel == J_TYPE) ? (!fits_20 || imm[0]) :
                                          1'b1;
   end

   assign in_ready = !out_valid || out_ready;
   assign hs       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         inst      <= '0;
         err       <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         inst      <= packed_inst;
         err       <= packed_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_count <= '0;
         err_count <= '0;
      end else begin
         enc_count <= cnt_clr ? '0 : hs ? enc_count + CNT_W'(1) : enc_count;
         err_count <= cnt_clr ? '0 : (hs && err && !(&err_count)) ? err_count + CNT_W'(1) : err_count;
      end
   end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed-vector bench for imm_encoder with hand-computed instruction words,
// error flags, backpressure, counter clear and asynchronous reset behaviour.
module tb_imm_encoder;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [2:0]  imm_sel;
   logic [31:0] imm;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic        out_valid, out_ready;
   logic [31:0] inst;
   logic        err;
   logic        cnt_clr;
   logic [15:0] enc_count, err_count;
   int          checks = 0;
   int          errors = 0;

   imm_encoder #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .imm_sel(imm_sel), .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .out_valid(out_valid), .out_ready(out_ready), .inst(inst),
      .err(err), .cnt_clr(cnt_clr), .enc_count(enc_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [2:0] s, input logic [31:0] i, input logic [6:0] op,
                       input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [2:0] f);
      in_valid = 1'b1;
      imm_sel  = s;
      imm      = i;
      opcode   = op;
      rd       = d;
      rs1      = r1;
      rs2      = r2;
      funct3   = f;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
      beat(3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
      in_valid = 1'b0;
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_enc_count", 32'(enc_count), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();

      beat(3'd0, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
      step();
      in_valid = 1'b0;
      chk("i_valid", 32'(out_valid), 32'd1);
      chk("i_inst", inst, 32'hFFF0_0093);
      chk("i_err", 32'(err), 32'd0);
      chk("i_cnt_pre", 32'(enc_count), 32'd0);
      step();
      chk("i_drain_valid", 32'(out_valid), 32'd0);
      chk("i_cnt", 32'(enc_count), 32'd1);

      beat(3'd1, 32'd8, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2);
      step();
      chk("s_inst", inst, 32'h0020_A423);
      chk("s_valid", 32'(out_valid), 32'd1);
      beat(3'd3, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0);
      step();
      in_valid = 1'b0;
      chk("u_inst", inst, 32'h1234_52B7);
      chk("u_valid", 32'(out_valid), 32'd1);
      chk("u_err", 32'(err), 32'd0);
      chk("su_cnt_mid", 32'(enc_count), 32'd2);
      step();
      chk("su_cnt", 32'(enc_count), 32'd3);

      beat(3'd2, 32'hFFFF_FFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0);
      step();
      chk("b_inst", inst, 32'hFE00_0EE3);
      chk("b_err", 32'(err), 32'd0);
      beat(3'd4, 32'd8, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0);
      step();
      in_valid = 1'b0;
      chk("j_inst", inst, 32'h0080_00EF);
      chk("j_err", 32'(err), 32'd0);
      step();
      chk("bj_cnt", 32'(enc_count), 32'd5);
      chk("bj_err_count", 32'(err_count), 32'd0);

      beat(3'd2, 32'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0);
      step();
      chk("eb_inst", inst, 32'h0000_0163);
      chk("eb_err", 32'(err), 32'd1);
      beat(3'd0, 32'h0000_0800, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0);
      step();
      chk("ei_inst", inst, 32'h8000_0013);
      chk("ei_err", 32'(err), 32'd1);
      beat(3'd3, 32'd1, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0);
      step();
      chk("eu_inst", inst, 32'h0000_0037);
      chk("eu_err", 32'(err), 32'd1);
      beat(3'd7, 32'hDEAD_BEEF, 7'h13, 5'd31, 5'd31, 5'd31, 3'd7);
      step();
      in_valid = 1'b0;
      chk("ill_inst", inst, 32'h0000_0013);
      chk("ill_err", 32'(err), 32'd1);
      step();
      chk("err_count4", 32'(err_count), 32'd4);
      chk("err_enc_cnt", 32'(enc_count), 32'd9);

      out_ready = 1'b0;
      beat(3'd0, 32'd5, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0);
      step();
      chk("bp_first", inst, 32'h0050_0113);
      beat(3'd0, 32'd6, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp_in_ready%0d", k), 32'(in_ready), 32'd0);
         chk($sformatf("bp_hold%0d", k), inst, 32'h0050_0113);
         chk($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
         step();
      end
      chk("bp_cnt_held", 32'(enc_count), 32'd9);
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_second", inst, 32'h0060_0193);
      chk("bp_second_valid", 32'(out_valid), 32'd1);
      step();
      chk("bp_drained", 32'(out_valid), 32'd0);
      chk("bp_cnt", 32'(enc_count), 32'd11);

      beat(3'd0, 32'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0);
      step();
      in_valid = 1'b0;
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr_enc", 32'(enc_count), 32'd0);
      chk("clr_err", 32'(err_count), 32'd0);

      beat(3'd3, 32'd1, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0);
      step();
      in_valid = 1'b0;
      step();
      chk("pre_rst_enc", 32'(enc_count), 32'd1);
      chk("pre_rst_err", 32'(err_count), 32'd1);
      out_ready = 1'b0;
      beat(3'd0, 32'd7, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0);
      step();
      in_valid = 1'b0;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_inst", inst, 32'd0);
      chk("async_rst_enc", 32'(enc_count), 32'd0);
      chk("async_rst_err", 32'(err_count), 32'd0);
      step();
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/imm_encoder.md
# imm_encoder

- Streaming RV32I instruction encoder; the inverse of the immediate generator.
- Accepts an immediate, format select and register/opcode fields, and emits a packed 32-bit instruction word.
- Flags immediates that the selected format cannot represent, and keeps encode and error counters.
- Sits between the self-test/program-loader sequencer and instruction memory write port; one-stage registered pipeline with valid/ready on both sides.

## Interface

Parameters:

- CNT_W, 16, width of `enc_count` and `err_count`

Ports:

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when `in_valid && in_ready`
- imm_sel  in  3  format select, values from imm_sel.vh: I_TYPE=0, S_TYPE=1, B_TYPE=2, U_TYPE=3, J_TYPE=4; 5–7 illegal
- imm  in  32  full-width immediate value
- opcode  in  7  inst[6:0]
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  function field
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- inst  out  32  encoded instruction
- err  out  1  encoding error for this beat, qualified by `out_valid`
- cnt_clr  in  1  synchronous clear of both counters
- enc_count  out  CNT_W  beats delivered; wraps modulo 2^CNT_W
- err_count  out  CNT_W  beats delivered with `err=1`; saturates at all-ones

## Operation

Packing is driven by `imm_sel`. `inst[6:0]` is always `opcode`. Fields not listed for a format are zero.

- **I:** [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
- **S:** [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0].
- **B:** [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11].
- **U:** [31:12]=imm[31:12], [11:7]=rd.
- **J:** [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], [11:7]=rd.
- **Illegal sel:** inst[31:7]=0, inst[6:0]=opcode, err=1.

Error rules (`err=1`); the beat is still emitted, packed from the truncated bits as above:

- I/S: imm[31:11] not all equal.
- B: imm[31:12] not all equal, or imm[0]=1.
- J: imm[31:20] not all equal, or imm[0]=1.
- U: imm[11:0] nonzero.

Counters:

- Update on output handshake (`out_valid && out_ready`).
- `enc_count` += 1.
- `err_count` += 1 when `err` is set and `err_count` is not at all-ones.
- `cnt_clr` has priority over an increment in the same cycle.

## Timing

- Reset: `out_valid`=0, `inst`=0, `err`=0, `enc_count`=0, `err_count`=0.
- `in_ready` = !out_valid || out_ready. Combinational, so `in_ready`=1 during reset.
- Latency: beat accepted at edge N appears on `inst`/`err` with `out_valid`=1 after edge N.
- Throughput: 1 beat/cycle when `out_ready` is held at 1.
- Simultaneous output handshake and new input acceptance: register reloads with the new beat; `out_valid` stays 1 with no bubble.
- Output handshake with no new input: `out_valid` falls the next cycle.
- While `out_valid && !out_ready`: `inst`, `err` and `out_valid` hold stable, and the input is not accepted.
- Reset asserted mid-stream: the in-flight beat is discarded, all outputs go to reset values immediately (asynchronous), and counters are cleared.
- Counter outputs are registered; each reflects a handshake on the cycle after that handshake.

## Test plan

- **I encode:** imm_sel=0, imm=0xFFFFFFFF, rd=1, rs1=0, funct3=0, opcode=0x13 -> inst=0xFFF00093, err=0, one cycle after acceptance.
- **S and U encode, back-to-back, out_ready=1:**
  - S beat: imm=8, rs2=2, rs1=1, funct3=2, opcode=0x23 -> 0x0020A423.
  - U beat: imm=0x12345000, rd=5, opcode=0x37 -> 0x123452B7.
  - Delivered on consecutive cycles; enc_count=2.
- **B/J encode:**
  - B: imm=0xFFFFFFFC, rs1=rs2=0, funct3=0, opcode=0x63 -> 0xFE000EE3.
  - J: imm=8, rd=1, opcode=0x6F -> 0x008000EF.
- **Errors:**
  - B with imm=3 -> err=1.
  - I with imm=0x800 -> err=1.
  - U with imm=0x1 -> err=1.
  - imm_sel=7, opcode=0x13 -> inst=0x00000013, err=1.
  - After the four beats: err_count=4.
- **Backpressure:**
  - Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, inst stable, only one beat accepted.
  - Release -> beats drain in order with no loss or duplication.
- **Reset/clear:**
  - Assert rst_n=0 mid-stream with out_valid=1 -> out_valid drops immediately and counters read 0.
  - Pulse cnt_clr on the same cycle as a handshake -> counters read 0.
